// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: connection bundle between the fetch-stage next-PC
// controller and the rest of the core (PC register, hazard unit, decode,
// execute, interrupt source).
//
//   master : the sequencer side. It drives the PC load controls, the flush,
//            the interrupt acknowledge and the architectural flags.
//   slave  : the core side. It drives the current PC, the redirect requests,
//            the stall, the halt and the interrupt request.
//
// Signals:
//   Pc_cur     core -> seq  current PC register value
//   Pc_en      seq -> core  PC register load enable
//   Pc_next    seq -> core  PC register data input
//   Stall      core -> seq  hazard unit holds fetch
//   Br_taken   core -> seq  EX-stage branch resolved taken
//   Br_target  core -> seq  branch destination
//   Jmp        core -> seq  ID-stage unconditional jump
//   Jmp_target core -> seq  jump destination
//   Ret        core -> seq  return-from-interrupt decoded
//   Halt       core -> seq  HALT instruction decoded
//   Irq_req    core -> seq  level-sensitive interrupt request
//   Irq_ack    seq -> core  one-cycle interrupt acceptance pulse
//   Flush      seq -> core  squash IF/ID (and ID/EX) this cycle
//   Epc        seq -> core  saved return address
//   Ie         seq -> core  interrupt-enable flag
//   Halted     seq -> core  high while in HALT state
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic [PC_W-1:0] Pc_cur;
  logic            Pc_en;
  logic [PC_W-1:0] Pc_next;
  logic            Stall;
  logic            Br_taken;
  logic [PC_W-1:0] Br_target;
  logic            Jmp;
  logic [PC_W-1:0] Jmp_target;
  logic            Ret;
  logic            Halt;
  logic            Irq_req;
  logic            Irq_ack;
  logic            Flush;
  logic [PC_W-1:0] Epc;
  logic            Ie;
  logic            Halted;

  modport master (
    input  Pc_cur, Stall, Br_taken, Br_target, Jmp, Jmp_target,
           Ret, Halt, Irq_req,
    output Pc_en, Pc_next, Irq_ack, Flush, Epc, Ie, Halted
  );

  modport slave (
    output Pc_cur, Stall, Br_taken, Br_target, Jmp, Jmp_target,
           Ret, Halt, Irq_req,
    input  Pc_en, Pc_next, Irq_ack, Flush, Epc, Ie, Halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address controller for the fetch-stage program counter.
//
// Every cycle it picks one next-PC source (sequential, branch, jump,
// interrupt vector, return-from-interrupt) and drives the PC register's load
// enable and data input. It also owns the boot fetch, halt/wake, the
// interrupt-enable flag and the saved exception PC, and raises Flush on
// every redirect.
//
// Ports:
//   CLK    system clock, all state changes on its rising edge
//   RST_N  asynchronous active-low reset
//   bus    pc_sequencer_if.master (see pc_sequencer_if.sv for the signals)
//
// Pc_en, Pc_next, Flush and Irq_ack are combinational from the state and the
// inputs, so the PC register loads on the same edge that this block updates
// its own state.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = 'h00,
  parameter logic [PC_W-1:0] IRQ_VEC   = 'hF0
) (
  input logic             CLK,
  input logic             RST_N,
  pc_sequencer_if.master  bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [PC_W-1:0] epc_q;
  logic [PC_W-1:0] epc_d;
  logic            ie_q;
  logic            ie_d;

  logic            pc_en_c;
  logic [PC_W-1:0] pc_next_c;
  logic            flush_c;
  logic            ack_c;

  // Sequential fetch address; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

  // In RUN a stalled cycle cannot take an interrupt because the PC it would
  // save is not stable; the request simply stays pending while held high.
  // In HALT nothing is in flight, so Stall does not matter.
  logic irq_ok_run;
  logic irq_ok_halt;

  assign irq_ok_run  = bus.Irq_req && ie_q && !bus.Stall;
  assign irq_ok_halt = bus.Irq_req && ie_q;

  always_comb begin
    pc_en_c   = 1'b0;
    pc_next_c = bus.Pc_cur;
    flush_c   = 1'b0;
    ack_c     = 1'b0;
    state_d   = state_q;
    epc_d     = epc_q;
    ie_d      = ie_q;

    case (state_q)
      ST_BOOT: begin
        // Requests are ignored on the boot fetch.
        pc_en_c   = 1'b1;
        pc_next_c = RESET_VEC;
        flush_c   = 1'b1;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // Fixed priority. A redirect outranks Halt because the halting
        // instruction is then on the wrong path and must be discarded.
        if (bus.Br_taken) begin
          pc_en_c   = 1'b1;
          pc_next_c = bus.Br_target;
          flush_c   = 1'b1;
        end else if (bus.Jmp) begin
          pc_en_c   = 1'b1;
          pc_next_c = bus.Jmp_target;
          flush_c   = 1'b1;
        end else if (bus.Ret) begin
          pc_en_c   = 1'b1;
          pc_next_c = epc_q;
          flush_c   = 1'b1;
          ie_d      = 1'b1;
        end else if (irq_ok_run) begin
          pc_en_c   = 1'b1;
          pc_next_c = IRQ_VEC;
          flush_c   = 1'b1;
          ack_c     = 1'b1;
          epc_d     = bus.Pc_cur;
          ie_d      = 1'b0;
        end else if (bus.Stall) begin
          pc_en_c   = 1'b0;
        end else if (bus.Halt) begin
          pc_en_c   = 1'b0;
          state_d   = ST_HALT;
        end else begin
          pc_en_c   = 1'b1;
          pc_next_c = pc_inc(bus.Pc_cur);
        end
      end

      ST_HALT: begin
        // Only an enabled interrupt wakes the core; with Ie clear the
        // only way out is reset.
        if (irq_ok_halt) begin
          pc_en_c   = 1'b1;
          pc_next_c = IRQ_VEC;
          flush_c   = 1'b1;
          ack_c     = 1'b1;
          epc_d     = bus.Pc_cur;
          ie_d      = 1'b0;
          state_d   = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_BOOT;
      epc_q   <= '0;
      ie_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
    end
  end

  // The combinational outputs are forced to their idle values while reset is
  // held, so a reset in the middle of a cycle takes effect immediately rather
  // than waiting for the state register to be observed.
  assign bus.Pc_en   = RST_N && pc_en_c;
  assign bus.Pc_next = RST_N ? pc_next_c : RESET_VEC;
  assign bus.Flush   = RST_N && flush_c;
  assign bus.Irq_ack = RST_N && ack_c;
  assign bus.Halted  = RST_N && (state_q == ST_HALT);
  assign bus.Epc     = epc_q;
  assign bus.Ie      = ie_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer. The bench plays the PC
// register: whenever the sequencer asserts Pc_en, the bench loads Pc_next
// into Pc_cur on the clock edge. Some steps override Pc_cur directly to
// place the core at a chosen address.
module tb_pc_sequencer;

  logic       CLK;
  logic       RST_N;

  logic [7:0] pc_cur;
  logic       stall;
  logic       br;
  logic [7:0] brt;
  logic       jmp;
  logic [7:0] jt;
  logic       ret;
  logic       halt;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic [7:0] nx;
    logic       fl;
    logic       ak;
  } exp_t;

  exp_t sb[$];

  pc_sequencer_if #(.PC_W(8)) bus ();

  assign bus.Pc_cur     = pc_cur;
  assign bus.Stall      = stall;
  assign bus.Br_taken   = br;
  assign bus.Br_target  = brt;
  assign bus.Jmp        = jmp;
  assign bus.Jmp_target = jt;
  assign bus.Ret        = ret;
  assign bus.Halt       = halt;
  assign bus.Irq_req    = irq;

  pc_sequencer #(
    .PC_W      (8),
    .RESET_VEC (8'h00),
    .IRQ_VEC   (8'hF0)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: expectation queued with the stimulus already applied,
  // popped and compared at the falling edge, then the PC register update.
  // Pc_next is only meaningful when Pc_en is expected high.
  task automatic cyc(input string tag, input logic en, input logic [7:0] nx,
                     input logic fl, input logic ak);
    exp_t       e;
    logic       ld;
    logic [7:0] nv;
    sb.push_back('{en: en, nx: nx, fl: fl, ak: ak});
    @(negedge CLK);
    e = sb.pop_front();
    chk({tag, ".en"}, {7'b0, bus.Pc_en}, {7'b0, e.en});
    if (e.en) chk({tag, ".next"}, bus.Pc_next, e.nx);
    chk({tag, ".flush"}, {7'b0, bus.Flush}, {7'b0, e.fl});
    chk({tag, ".ack"}, {7'b0, bus.Irq_ack}, {7'b0, e.ak});
    ld = bus.Pc_en;
    nv = bus.Pc_next;
    @(posedge CLK);
    #1;
    if (ld) pc_cur = nv;
  endtask

  initial begin
    RST_N  = 1'b0;
    pc_cur = 8'h00;
    stall  = 1'b0;
    br     = 1'b0;
    brt    = 8'h00;
    jmp    = 1'b0;
    jt     = 8'h00;
    ret    = 1'b0;
    halt   = 1'b0;
    irq    = 1'b0;

    repeat (2) @(posedge CLK);
    #1;

    // Held in reset
    cyc("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst.next", bus.Pc_next, 8'h00);
    chk("rst.halted", {7'b0, bus.Halted}, 8'h00);
    chk("rst.epc", bus.Epc, 8'h00);
    chk("rst.ie", {7'b0, bus.Ie}, 8'h01);

    // Boot and sequential fetch
    RST_N = 1'b1;
    cyc("boot", 1'b1, 8'h00, 1'b1, 1'b0);
    cyc("seq1", 1'b1, 8'h01, 1'b0, 1'b0);
    cyc("seq2", 1'b1, 8'h02, 1'b0, 1'b0);
    pc_cur = 8'hFF;
    cyc("wrap", 1'b1, 8'h00, 1'b0, 1'b0);

    // Stall holds the PC
    pc_cur = 8'h10;
    stall  = 1'b1;
    cyc("stall0", 1'b0, 8'h10, 1'b0, 1'b0);
    cyc("stall1", 1'b0, 8'h10, 1'b0, 1'b0);
    cyc("stall2", 1'b0, 8'h10, 1'b0, 1'b0);
    stall = 1'b0;
    cyc("unstall", 1'b1, 8'h11, 1'b0, 1'b0);

    // Branch outranks jump, stall and halt
    br = 1'b1; brt = 8'h40; jmp = 1'b1; jt = 8'h80; stall = 1'b1; halt = 1'b1;
    cyc("prio", 1'b1, 8'h40, 1'b1, 1'b0);
    chk("prio.halted", {7'b0, bus.Halted}, 8'h00);
    br = 1'b0; stall = 1'b0; halt = 1'b0;
    cyc("jmp", 1'b1, 8'h80, 1'b1, 1'b0);
    jmp = 1'b0;
    cyc("after_jmp", 1'b1, 8'h81, 1'b0, 1'b0);

    // Interrupt deferred by stall, then taken
    pc_cur = 8'h23;
    irq    = 1'b1;
    stall  = 1'b1;
    cyc("irq_stall0", 1'b0, 8'h23, 1'b0, 1'b0);
    cyc("irq_stall1", 1'b0, 8'h23, 1'b0, 1'b0);
    stall = 1'b0;
    cyc("irq_take", 1'b1, 8'hF0, 1'b1, 1'b1);
    chk("irq_take.epc", bus.Epc, 8'h23);
    chk("irq_take.ie", {7'b0, bus.Ie}, 8'h00);
    cyc("irq_nonest", 1'b1, 8'hF1, 1'b0, 1'b0);

    // Return re-enables interrupts; Ret beats a simultaneous interrupt
    ret = 1'b1;
    cyc("ret", 1'b1, 8'h23, 1'b1, 1'b0);
    chk("ret.ie", {7'b0, bus.Ie}, 8'h01);
    cyc("ret_vs_irq", 1'b1, 8'h23, 1'b1, 1'b0);
    ret = 1'b0;
    cyc("irq_again", 1'b1, 8'hF0, 1'b1, 1'b1);
    chk("irq_again.epc", bus.Epc, 8'h23);
    irq = 1'b0;
    ret = 1'b1;
    cyc("ret2", 1'b1, 8'h23, 1'b1, 1'b0);
    chk("ret2.ie", {7'b0, bus.Ie}, 8'h01);
    ret = 1'b0;

    // Halt and wake by interrupt
    pc_cur = 8'h30;
    halt   = 1'b1;
    cyc("halt", 1'b0, 8'h30, 1'b0, 1'b0);
    chk("halt.halted", {7'b0, bus.Halted}, 8'h01);
    br = 1'b1; brt = 8'h55;
    cyc("halt_ignbr", 1'b0, 8'h30, 1'b0, 1'b0);
    chk("halt_ignbr.halted", {7'b0, bus.Halted}, 8'h01);
    br = 1'b0; halt = 1'b0; irq = 1'b1;
    cyc("wake", 1'b1, 8'hF0, 1'b1, 1'b1);
    chk("wake.halted", {7'b0, bus.Halted}, 8'h00);
    chk("wake.epc", bus.Epc, 8'h30);
    chk("wake.ie", {7'b0, bus.Ie}, 8'h00);

    // Halt with interrupts disabled stays halted
    irq  = 1'b0;
    halt = 1'b1;
    cyc("halt_noie", 1'b0, 8'hF0, 1'b0, 1'b0);
    halt = 1'b0;
    irq  = 1'b1;
    cyc("stuck0", 1'b0, 8'hF0, 1'b0, 1'b0);
    cyc("stuck1", 1'b0, 8'hF0, 1'b0, 1'b0);
    cyc("stuck2", 1'b0, 8'hF0, 1'b0, 1'b0);
    chk("stuck.halted", {7'b0, bus.Halted}, 8'h01);

    // Reset leaves halt and restores flags
    RST_N = 1'b0;
    #1;
    chk("rst_halt.halted", {7'b0, bus.Halted}, 8'h00);
    chk("rst_halt.epc", bus.Epc, 8'h00);
    chk("rst_halt.ie", {7'b0, bus.Ie}, 8'h01);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    irq   = 1'b0;
    cyc("boot2", 1'b1, 8'h00, 1'b1, 1'b0);
    cyc("seq3", 1'b1, 8'h01, 1'b0, 1'b0);

    // Reset in the middle of an interrupt-entry cycle
    irq = 1'b1;
    #1;
    chk("entry.ack", {7'b0, bus.Irq_ack}, 8'h01);
    RST_N = 1'b0;
    #1;
    chk("mid_rst.en", {7'b0, bus.Pc_en}, 8'h00);
    chk("mid_rst.ack", {7'b0, bus.Irq_ack}, 8'h00);
    chk("mid_rst.flush", {7'b0, bus.Flush}, 8'h00);
    chk("mid_rst.next", bus.Pc_next, 8'h00);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    irq   = 1'b0;
    cyc("boot3", 1'b1, 8'h00, 1'b1, 1'b0);
    chk("boot3.epc", bus.Epc, 8'h00);
    chk("boot3.ie", {7'b0, bus.Ie}, 8'h01);
    cyc("seq4", 1'b1, 8'h01, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
